bin2gray_enc: RTL and testbench

Registered binary-to-Gray encoder with a valid/ready stream interface and a two-entry skid buffer on the output. Upstream logic uses it to convert binary counters or pointers to Gray code before they cross into the domain that feeds the existing Gray-to-binary decoder. Throughput is one word per cycle under continuous flow, and backpressure is fully absorbed. An optional checker flags consecutive outputs that are not single-bit adjacent.

---
 rtl/bin2gray_pkg.sv | 14 +
 rtl/bin2gray_enc_skid_buf.sv | 91 +++++++++
 rtl/bin2gray_enc.sv | 70 +++++++
 tb/tb_bin2gray_enc.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bin2gray_pkg.sv
// Shared types, constants and the Gray encoding helper for the bin2gray encoder.
package bin2gray_pkg;

    localparam int unsigned MAX_W     = 64;
    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} skid_state_t;

    // Fixed maximum width; callers zero-extend the operand and truncate the result.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/bin2gray_enc_skid_buf.sv
// skid_buf: generic W-bit valid/ready two-entry skid buffer with a registered in_ready.
module skid_buf
    import bin2gray_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t  state;
    skid_state_t  state_next;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         in_xfer;
    logic         out_xfer;
    logic         load_main;
    logic         load_skid;
    logic         from_skid;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_next = state;
        load_main  = 1'b0;
        load_skid  = 1'b0;
        from_skid  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end else if (in_xfer) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    from_skid  = 1'b1;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != FULL);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/bin2gray_enc.sv
// Registered binary-to-Gray encoder with valid/ready skid buffering.
// Optional adjacency checker enabled by defining BIN2GRAY_ADJ_CHECK_EN.
module bin2gray_enc
    import bin2gray_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_gray
`ifdef BIN2GRAY_ADJ_CHECK_EN
    ,
    output logic                 adj_err,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic [N-1:0] enc;

    assign enc = N'(bin2gray(MAX_W'(in_bin)));

    skid_buf #(
        .W(N)
    ) u_skid_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (enc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_gray)
    );

`ifdef BIN2GRAY_ADJ_CHECK_EN
    logic [N-1:0] prev;
    logic         have_prev;
    logic         out_xfer;

    assign out_xfer = out_valid && out_ready;

    // The first word after reset only seeds prev; it is never checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= '0;
            have_prev <= 1'b0;
            adj_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            adj_err <= 1'b0;
            if (out_xfer) begin
                prev      <= out_gray;
                have_prev <= 1'b1;
                if (have_prev && ($countones(out_gray ^ prev) != 1)) begin
                    adj_err <= 1'b1;
                    if (err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bin2gray_enc.sv
// Self-checking bench for bin2gray_enc: directed cases plus randomized flow against a FIFO reference model.
module tb_bin2gray_enc;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_bin = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_gray;
`ifdef BIN2GRAY_ADJ_CHECK_EN
    logic       adj_err;
    logic [7:0] err_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: an ordered queue of at most two pending Gray words.
    logic [7:0] q[$];
    logic [7:0] prev_out;
    bit         have_prev;
    int unsigned exp_cnt;
    bit         exp_pulse;

    always #5 clk = ~clk;

    bin2gray_enc #(
        .N(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_gray (out_gray)
`ifdef BIN2GRAY_ADJ_CHECK_EN
        ,
        .adj_err  (adj_err),
        .err_cnt  (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gray_ref(input logic [7:0] b);
        return b ^ (b / 2);
    endfunction

    function automatic int unsigned diff_bits(input logic [7:0] a, input logic [7:0] b);
        int unsigned c = 0;
        for (int i = 0; i < 8; i++) begin
            if (a[i] != b[i]) c++;
        end
        return c;
    endfunction

    task automatic check_state();
        check("out_valid", out_valid, (q.size() > 0));
        check("in_ready", in_ready, (q.size() < 2));
        if (q.size() > 0) check("out_gray", out_gray, q[0]);
`ifdef BIN2GRAY_ADJ_CHECK_EN
        check("adj_err", adj_err, exp_pulse);
        check("err_cnt", err_cnt, exp_cnt);
`endif
    endtask

    // Called at posedge+1: drive inputs, advance the model, then check after the next edge.
    task automatic cycle(input logic v, input logic [7:0] b, input logic r);
        bit in_x;
        bit out_x;
        in_valid  = v;
        in_bin    = b;
        out_ready = r;
        in_x      = v && (q.size() < 2);
        out_x     = r && (q.size() > 0);
        exp_pulse = 1'b0;
        if (out_x) begin
            if (have_prev && diff_bits(q[0], prev_out) != 1) begin
                exp_pulse = 1'b1;
                if (exp_cnt < 255) exp_cnt++;
            end
            prev_out  = q[0];
            have_prev = 1'b1;
            void'(q.pop_front());
        end
        if (in_x) q.push_back(gray_ref(b));
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_gray", out_gray, 8'h00);
`ifdef BIN2GRAY_ADJ_CHECK_EN
        check("rst_adj_err", adj_err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'h00);
`endif
        q.delete();
        have_prev = 1'b0;
        exp_cnt   = 0;
        exp_pulse = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        check_state();
    endtask

    initial begin
        #2;
        do_reset();

        // Single word, one-cycle latency, then empty again.
        cycle(1'b1, 8'h01, 1'b1);
        check("t1_gray", out_gray, 8'h01);
        cycle(1'b0, 8'h00, 1'b1);
        check("t1_empty", out_valid, 1'b0);

        // Back-to-back stream with out_ready held high.
        cycle(1'b1, 8'h06, 1'b1);
        check("t2_gray0", out_gray, 8'h05);
        cycle(1'b1, 8'h04, 1'b1);
        check("t2_gray1", out_gray, 8'h06);
        cycle(1'b1, 8'h07, 1'b1);
        check("t2_gray2", out_gray, 8'h04);
        check("t2_ready", in_ready, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);

        // Backpressure: two words absorbed, third refused until space frees.
        cycle(1'b1, 8'h05, 1'b0);
        cycle(1'b1, 8'h02, 1'b0);
        check("t3_full", in_ready, 1'b0);
        cycle(1'b1, 8'h03, 1'b0);
        check("t3_hold", out_gray, 8'h07);
        cycle(1'b1, 8'h03, 1'b1);
        check("t3_next", out_gray, 8'h03);
        cycle(1'b1, 8'h03, 1'b1);
        check("t3_last", out_gray, 8'h02);
        cycle(1'b0, 8'h00, 1'b1);

        // Reset while FULL discards both buffered words.
        cycle(1'b1, 8'h11, 1'b0);
        cycle(1'b1, 8'h22, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        check("t4_no_stale", out_valid, 1'b0);

`ifdef BIN2GRAY_ADJ_CHECK_EN
        cycle(1'b1, 8'h00, 1'b1);
        cycle(1'b1, 8'h01, 1'b1);
        cycle(1'b1, 8'h03, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("t5_pulse", adj_err, 1'b1);
        check("t5_cnt1", err_cnt, 8'd1);
        cycle(1'b0, 8'h00, 1'b1);
        check("t5_pulse_end", adj_err, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, (i % 2 == 0) ? 8'h05 : 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b1);
        check("t5_sat", err_cnt, 8'd255);
        do_reset();
`endif

        // Randomized valid/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
        check("drained", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
